// File: rtl/clock_edit_ctrl.sv
// Front-panel controller for the digital clock: synchronizes and debounces the
// four buttons, runs the VIEW/EDIT state machine and produces the inc/dec
// strobes (with auto-repeat), cursor position, screen select and cursor blink.
module clock_edit_ctrl #(
   parameter int DEBOUNCE_TICKS = 2,
   parameter int REPEAT_DELAY   = 8,
   parameter int REPEAT_RATE    = 2,
   parameter int TIMEOUT_TICKS  = 30,
   parameter int BLINK_TICKS    = 4,
   parameter int NUM_POS        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_mode_n,
   input  logic       btn_edit_n,
   input  logic       btn_plus_n,
   input  logic       btn_minus_n,
   output logic [1:0] screen,
   output logic       edit_mode,
   output logic [2:0] edit_pos,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       blink
);

   localparam int DB_W    = $clog2(DEBOUNCE_TICKS + 1);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam int TO_W    = $clog2(TIMEOUT_TICKS + 1);
   localparam int BL_W    = $clog2(BLINK_TICKS + 1);

   localparam int KEY_MODE  = 0;
   localparam int KEY_EDIT  = 1;
   localparam int KEY_PLUS  = 2;
   localparam int KEY_MINUS = 3;

   typedef enum logic {VIEW, EDIT} state_t;

   state_t           state;
   logic [3:0]       sync_p0;
   logic [3:0]       sync_p1;
   logic [3:0]       deb;
   logic [3:0]       deb_prev;
   logic [3:0]       press;
   logic [DB_W-1:0]  db_cnt [4];
   logic [TO_W-1:0]  to_cnt;
   logic [BL_W-1:0]  bl_cnt;
   logic [REP_W-1:0] rep_cnt;
   logic             rep_phase;
   logic             arm_inc;
   logic             arm_dec;
   logic             both_held;
   logic             key_held;
   logic             rep_hit;
   logic             rep_fire;
   logic             timeout_hit;
   logic             last_pos;
   logic             leave;

   // Two-flop synchronizer; bits are converted to active-high "pressed"
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= ~{btn_minus_n, btn_plus_n, btn_edit_n, btn_mode_n};
         sync_p1 <= sync_p0;
      end
   end

   // Debounce: flip only after the synchronized level disagrees on consecutive ticks
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else if (tick) begin
         for (int i = 0; i < 4; i++) begin
            if (sync_p1[i] != deb[i]) begin
               if (db_cnt[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
                  deb[i]    <= sync_p1[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Previous debounced state, for released->pressed edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) deb_prev <= '0;
      else        deb_prev <= deb;
   end

   assign press       = deb & ~deb_prev;
   assign both_held   = deb[KEY_PLUS] & deb[KEY_MINUS];
   assign key_held    = (arm_inc & deb[KEY_PLUS]) | (arm_dec & deb[KEY_MINUS]);
   assign rep_hit     = rep_phase ? (rep_cnt == REP_W'(REPEAT_RATE - 1))
                                  : (rep_cnt == REP_W'(REPEAT_DELAY - 1));
   assign rep_fire    = tick & ~both_held & key_held & rep_hit;
   assign timeout_hit = tick & (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
   assign last_pos    = (edit_pos == 3'(NUM_POS - 1));
   // A press in the same clk pre-empts tick-driven behaviour, including timeout
   assign leave       = (state == EDIT) &
                        (press[KEY_MODE] | (press[KEY_EDIT] & last_pos) |
                         (~|press & timeout_hit));

   // VIEW/EDIT state machine with registered outputs, repeat, timeout and blink
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= VIEW;
         screen    <= '0;
         edit_mode <= 1'b0;
         edit_pos  <= '0;
         inc_pulse <= 1'b0;
         dec_pulse <= 1'b0;
         blink     <= 1'b0;
         to_cnt    <= '0;
         bl_cnt    <= '0;
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
         arm_inc   <= 1'b0;
         arm_dec   <= 1'b0;
      end else begin
         inc_pulse <= 1'b0;
         dec_pulse <= 1'b0;
         if (leave) begin
            state     <= VIEW;
            edit_mode <= 1'b0;
            edit_pos  <= '0;
            blink     <= 1'b0;
            arm_inc   <= 1'b0;
            arm_dec   <= 1'b0;
            rep_cnt   <= '0;
         end else if (state == VIEW) begin
            if (press[KEY_MODE]) begin
               screen <= screen + 2'd1;
            end else if (press[KEY_EDIT]) begin
               state     <= EDIT;
               edit_mode <= 1'b1;
               edit_pos  <= '0;
               to_cnt    <= '0;
               bl_cnt    <= '0;
               blink     <= 1'b1;
               arm_inc   <= 1'b0;
               arm_dec   <= 1'b0;
            end
         end else begin
            if (press[KEY_EDIT]) begin
               edit_pos <= edit_pos + 3'd1;
               blink    <= 1'b1;
               bl_cnt   <= '0;
               to_cnt   <= '0;
            end else if (press[KEY_PLUS] | press[KEY_MINUS]) begin
               to_cnt    <= '0;
               rep_cnt   <= '0;
               rep_phase <= 1'b0;
               if (both_held) begin
                  arm_inc <= 1'b0;
                  arm_dec <= 1'b0;
               end else if (press[KEY_PLUS]) begin
                  inc_pulse <= 1'b1;
                  arm_inc   <= 1'b1;
                  arm_dec   <= 1'b0;
               end else begin
                  dec_pulse <= 1'b1;
                  arm_dec   <= 1'b1;
                  arm_inc   <= 1'b0;
               end
            end else if (tick) begin
               if (bl_cnt == BL_W'(BLINK_TICKS - 1)) begin
                  blink  <= ~blink;
                  bl_cnt <= '0;
               end else begin
                  bl_cnt <= bl_cnt + BL_W'(1);
               end
               if (rep_fire) begin
                  inc_pulse <= arm_inc;
                  dec_pulse <= arm_dec;
                  rep_cnt   <= '0;
                  rep_phase <= 1'b1;
                  to_cnt    <= '0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
                  if (!both_held && key_held) begin
                     rep_cnt <= rep_cnt + REP_W'(1);
                  end else begin
                     // Released, or both keys down: a fresh press is needed to repeat again
                     arm_inc <= 1'b0;
                     arm_dec <= 1'b0;
                     rep_cnt <= '0;
                  end
               end
            end
         end
      end
   end

endmodule
